idecode_pipe: RTL and testbench

Parametrised instruction-decode stage for the 32-bit pipelined core: holds the register file, reads two source operands, selects the PC or a register as left operand, and forms the immediate. It adds writeback-to-decode bypass, load-use hazard stall, flush, and valid/ready handshakes on both sides. It sits between the fetch stage and the execute stage; writeback drives its write port.

---
 rtl/idecode_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_idecode_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idecode_pipe.sv
// idecode_pipe -- instruction-decode stage of the 32-bit pipelined core.
//
// Holds the register file, reads two source operands (with a writeback
// bypass), picks PC or rs as the left operand, forms the immediate and
// presents one registered decode bundle to execute. Also contains a
// load-use hazard stall, a flush, and valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop the output slot, refuse input this cycle
//   in_valid / in_ready       fetch-side handshake
//   in_pc, in_inst, in_svpc   instruction, its PC, "left operand is PC"
//   wb_we, wb_addr, wb_data   register file write port (from writeback)
//   out_valid / out_ready     execute-side handshake
//   out_pc, out_lhs, out_rhs  PC, left operand, rt value
//   out_imm, out_rd, out_op   extended immediate, destination, opcode
//
// Instruction fields: op=[31:28], rd=[27:22], rs=[21:16], rt=[15:10];
// only the low REG_AW bits of each register field are used.

module idecode_pipe #(
    parameter int         XLEN       = 32,
    parameter int         REG_AW     = 6,
    parameter bit         R0_ZERO    = 1'b0,
    parameter bit         IMM_SIGNED = 1'b0,
    parameter logic [3:0] LD_OP      = 4'b0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    input  logic              in_svpc,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_lhs,
    output logic [XLEN-1:0]   out_rhs,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [3:0]        out_op
);

    localparam int NREG = 2 ** REG_AW;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Register 0 is hard-wired to zero only when R0_ZERO is set.
    function automatic logic is_zero_reg(input logic [REG_AW-1:0] a);
        return R0_ZERO && (a == '0);
    endfunction

    // Long form (inst[0]=1) carries 22 bits, short form 16 bits. The fill
    // word is built first and the payload dropped on top so that XLEN=22
    // needs no zero-width replication.
    function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] inst);
        logic [XLEN-1:0] res;
        logic            fill;
        if (inst[0]) begin
            fill       = IMM_SIGNED && inst[21];
            res        = {XLEN{fill}};
            res[21:0]  = inst[21:0];
        end else begin
            fill       = IMM_SIGNED && inst[15];
            res        = {XLEN{fill}};
            res[15:0]  = inst[15:0];
        end
        return res;
    endfunction

    // Source read: zero register, then same-cycle writeback, then array.
    function automatic logic [XLEN-1:0] src_val(
        input logic [REG_AW-1:0] a,
        input logic [XLEN-1:0]   arr,
        input logic              we,
        input logic [REG_AW-1:0] wa,
        input logic [XLEN-1:0]   wd
    );
        if (is_zero_reg(a)) begin
            return '0;
        end
        if (we && (wa == a)) begin
            return wd;
        end
        return arr;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_pc_q,    out_pc_d;
    logic [XLEN-1:0]   out_lhs_q,   out_lhs_d;
    logic [XLEN-1:0]   out_rhs_q,   out_rhs_d;
    logic [XLEN-1:0]   out_imm_q,   out_imm_d;
    logic [REG_AW-1:0] out_rd_q,    out_rd_d;
    logic [3:0]        out_op_q,    out_op_d;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [3:0]        dec_op;
    logic [REG_AW-1:0] dec_rd;
    logic [REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0] dec_rt;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [XLEN-1:0]   lhs_val;
    logic [XLEN-1:0]   imm_val;

    assign dec_op  = in_inst[31:28];
    assign dec_rd  = in_inst[22 +: REG_AW];
    assign dec_rs  = in_inst[16 +: REG_AW];
    assign dec_rt  = in_inst[10 +: REG_AW];

    assign rs_val  = src_val(dec_rs, regs_q[dec_rs], wb_we, wb_addr, wb_data);
    assign rt_val  = src_val(dec_rt, regs_q[dec_rt], wb_we, wb_addr, wb_data);
    assign lhs_val = in_svpc ? in_pc : rs_val;
    assign imm_val = ext_imm(in_inst);

    // ------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------
    logic advance;
    logic out_is_load;
    logic rs_dep;
    logic rt_dep;
    logic hazard;
    logic accept;

    assign advance     = !out_valid_q || out_ready;
    assign out_is_load = (out_op_q == LD_OP);
    // A PC-relative instruction never reads rs, so it cannot depend on it.
    // The compare is deliberately not gated by R0_ZERO: a load to r0
    // still costs a bubble, which keeps this path short.
    assign rs_dep      = !in_svpc && (out_rd_q == dec_rs);
    assign rt_dep      = (out_rd_q == dec_rt);
    assign hazard      = in_valid && out_valid_q && out_is_load && (rs_dep || rt_dep);
    assign in_ready    = advance && !hazard && !flush && !rst;
    assign accept      = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Register file next state
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (wb_we && !is_zero_reg(wb_addr)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Output slot next state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_lhs_d   = out_lhs_q;
        out_rhs_d   = out_rhs_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_op_d    = out_op_q;

        if (flush) begin
            // Flush wins over a stalled slot too: the bundle is discarded
            // even when execute is not ready.
            out_valid_d = 1'b0;
        end else if (advance) begin
            // Covers capture, the load-use bubble and an idle input.
            out_valid_d = accept;
            if (accept) begin
                out_pc_d  = in_pc;
                out_lhs_d = lhs_val;
                out_rhs_d = rt_val;
                out_imm_d = imm_val;
                out_rd_d  = dec_rd;
                out_op_d  = dec_op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_lhs_q   <= '0;
            out_rhs_q   <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_op_q    <= '0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_lhs_q   <= out_lhs_d;
            out_rhs_q   <= out_rhs_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_op_q    <= out_op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_lhs   = out_lhs_q;
    assign out_rhs   = out_rhs_q;
    assign out_imm   = out_imm_q;
    assign out_rd    = out_rd_q;
    assign out_op    = out_op_q;

endmodule

// File: tb/tb_idecode_pipe.sv
// Bench for idecode_pipe. Two instances share all inputs: u_a uses the
// default parameters (R0_ZERO=0, IMM_SIGNED=0), u_b uses R0_ZERO=1 and
// IMM_SIGNED=1. Expected bundles are queued when an instruction is
// accepted; a monitor pops and compares on every output transfer.

module tb_idecode_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_svpc;
    logic        wb_we;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc, a_out_lhs, a_out_rhs, a_out_imm;
    logic [5:0]  a_out_rd;
    logic [3:0]  a_out_op;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_pc, b_out_lhs, b_out_rhs, b_out_imm;
    logic [5:0]  b_out_rd;
    logic [3:0]  b_out_op;

    idecode_pipe u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_svpc(in_svpc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_lhs(a_out_lhs), .out_rhs(a_out_rhs),
        .out_imm(a_out_imm), .out_rd(a_out_rd), .out_op(a_out_op)
    );

    idecode_pipe #(.R0_ZERO(1'b1), .IMM_SIGNED(1'b1)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_svpc(in_svpc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_lhs(b_out_lhs), .out_rhs(b_out_rhs),
        .out_imm(b_out_imm), .out_rd(b_out_rd), .out_op(b_out_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] lhs_a, rhs_a, imm_a;
        logic [31:0] lhs_b, rhs_b, imm_b;
        logic [5:0]  rd;
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                       input logic [5:0] rs, input logic [5:0] rt,
                                       input logic [9:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    // Monitor: one transfer per cycle when out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (a_out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_pc=%h, expected no bundle", a_out_pc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("a_pc_%0h", e.pc),    a_out_pc,        e.pc);
                    chk($sformatf("a_lhs_%0h", e.pc),   a_out_lhs,       e.lhs_a);
                    chk($sformatf("a_rhs_%0h", e.pc),   a_out_rhs,       e.rhs_a);
                    chk($sformatf("a_imm_%0h", e.pc),   a_out_imm,       e.imm_a);
                    chk($sformatf("a_rd_%0h", e.pc),    32'(a_out_rd),   32'(e.rd));
                    chk($sformatf("a_op_%0h", e.pc),    32'(a_out_op),   32'(e.op));
                    chk($sformatf("b_valid_%0h", e.pc), 32'(b_out_valid), 32'd1);
                    chk($sformatf("b_pc_%0h", e.pc),    b_out_pc,        e.pc);
                    chk($sformatf("b_lhs_%0h", e.pc),   b_out_lhs,       e.lhs_b);
                    chk($sformatf("b_rhs_%0h", e.pc),   b_out_rhs,       e.rhs_b);
                    chk($sformatf("b_imm_%0h", e.pc),   b_out_imm,       e.imm_b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    // Called just after a negedge; presents the instruction until accepted
    // (bounded), returns just after the following negedge with in_valid=0.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input logic svpc,
                         input bit push, input exp_t e, output int waits, output logic ov_acc);
        logic r, ov;
        bit   got;
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_svpc  = svpc;
        waits    = 0;
        ov_acc   = 1'b0;
        got      = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            r  = a_in_ready;
            ov = a_out_valid;
            @(posedge clk);
            if (r === 1'b1) begin
                if (push) sb.push_back(e);
                ov_acc = ov;
                got    = 1'b1;
            end
            @(negedge clk);
            if (got) break;
            waits++;
        end
        in_valid = 1'b0;
        if (!got) chk($sformatf("accept_timeout_%0h", pc), 32'd0, 32'd1);
    endtask

    task automatic go(input logic [31:0] pc, input logic [31:0] inst, input logic svpc,
                      input logic [31:0] la, input logic [31:0] ra, input logic [31:0] ia,
                      input logic [31:0] lb, input logic [31:0] rb, input logic [31:0] ib,
                      input int exp_waits, input int exp_ov);
        exp_t e;
        int   w;
        logic ov;
        e.pc = pc; e.lhs_a = la; e.rhs_a = ra; e.imm_a = ia;
        e.lhs_b = lb; e.rhs_b = rb; e.imm_b = ib;
        e.rd = inst[27:22]; e.op = inst[31:28];
        issue(pc, inst, svpc, 1'b1, e, w, ov);
        chk($sformatf("stall_cycles_%0h", pc), 32'(w), 32'(exp_waits));
        if (exp_ov >= 0) chk($sformatf("valid_at_accept_%0h", pc), 32'(ov), 32'(exp_ov));
    endtask

    task automatic wb_cycle(input logic [5:0] a, input logic [31:0] d);
        in_valid = 1'b0;
        wb_we    = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(posedge clk);
        @(negedge clk);
        wb_we    = 1'b0;
    endtask

    initial begin
        exp_t dummy;
        int   w;
        logic ov;
        dummy = '{default: '0};

        // Reset with a write to r5 and a pending instruction.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h99; in_inst = mk(4'd1, 6'd1, 6'd5, 6'd5, 10'd0); in_svpc = 1'b0;
        wb_we = 1'b1; wb_addr = 6'd5; wb_data = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
        chk("rst_pc", a_out_pc, 32'd0);
        chk("rst_lhs", a_out_lhs, 32'd0);
        chk("rst_rhs", a_out_rhs, 32'd0);
        chk("rst_imm", a_out_imm, 32'd0);
        chk("rst_rd_op", {22'd0, a_out_rd, a_out_op}, 32'd0);
        rst = 1'b0; in_valid = 1'b0; wb_we = 1'b0;
        @(negedge clk);

        // r5 write during reset was ignored.
        go(32'h100, mk(4'd1, 6'd1, 6'd5, 6'd5, 10'd0), 1'b0,
           32'h0, 32'h0, 32'h1400, 32'h0, 32'h0, 32'h1400, 0, -1);

        wb_cycle(6'd1, 32'h11);
        wb_cycle(6'd2, 32'h22);
        wb_cycle(6'd8, 32'h88);
        wb_cycle(6'd0, 32'h55);

        // Bypass: write r3 in the same cycle it is read on both sources.
        wb_we = 1'b1; wb_addr = 6'd3; wb_data = 32'hDEADBEEF;
        go(32'h104, mk(4'd2, 6'd4, 6'd3, 6'd3, 10'd0), 1'b0,
           32'hDEADBEEF, 32'hDEADBEEF, 32'hC00, 32'hDEADBEEF, 32'hDEADBEEF, 32'hC00, 0, -1);
        wb_we = 1'b0;

        // PC as left operand.
        go(32'h200, mk(4'd3, 6'd9, 6'd1, 6'd2, 10'd0), 1'b1,
           32'h200, 32'h22, 32'h800, 32'h200, 32'h22, 32'h800, 0, -1);
        // r0: holds 0x55 in u_a, reads zero in u_b.
        go(32'h108, mk(4'd5, 6'd10, 6'd0, 6'd0, 10'h3FF), 1'b0,
           32'h55, 32'h55, 32'h3FF, 32'h0, 32'h0, 32'h3FF, 0, -1);
        // 22-bit immediate of all ones.
        go(32'h10C, mk(4'd6, 6'd11, 6'd63, 6'd63, 10'h3FF), 1'b0,
           32'h0, 32'h0, 32'h003FFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, -1);
        // 16-bit immediate 0x8000.
        go(32'h110, mk(4'd7, 6'd12, 6'd2, 6'd32, 10'd0), 1'b0,
           32'h22, 32'h0, 32'h00008000, 32'h22, 32'h0, 32'hFFFF8000, 0, -1);

        // Load-use on rs: one stall cycle, accepted into a bubble.
        go(32'h120, mk(4'd4, 6'd7, 6'd1, 6'd2, 10'd0), 1'b0,
           32'h11, 32'h22, 32'h800, 32'h11, 32'h22, 32'h800, 0, -1);
        go(32'h124, mk(4'd1, 6'd13, 6'd7, 6'd1, 10'd0), 1'b0,
           32'h0, 32'h11, 32'h400, 32'h0, 32'h11, 32'h400, 1, 0);
        // Non-dependent after a load: no stall.
        go(32'h128, mk(4'd4, 6'd7, 6'd1, 6'd2, 10'd0), 1'b0,
           32'h11, 32'h22, 32'h800, 32'h11, 32'h22, 32'h800, 0, -1);
        go(32'h12C, mk(4'd1, 6'd14, 6'd8, 6'd1, 10'd0), 1'b0,
           32'h88, 32'h11, 32'h400, 32'h88, 32'h11, 32'h400, 0, 1);
        // Load-use on rt.
        go(32'h130, mk(4'd4, 6'd9, 6'd2, 6'd1, 10'd0), 1'b0,
           32'h22, 32'h11, 32'h400, 32'h22, 32'h11, 32'h400, 0, -1);
        go(32'h134, mk(4'd1, 6'd15, 6'd1, 6'd9, 10'd0), 1'b0,
           32'h11, 32'h0, 32'h2400, 32'h11, 32'h0, 32'h2400, 1, 0);
        // rs matches the load but the PC is the left operand: no stall.
        go(32'h138, mk(4'd4, 6'd7, 6'd2, 6'd2, 10'd0), 1'b0,
           32'h22, 32'h22, 32'h800, 32'h22, 32'h22, 32'h800, 0, -1);
        go(32'h13C, mk(4'd1, 6'd16, 6'd7, 6'd1, 10'd0), 1'b1,
           32'h13C, 32'h11, 32'h400, 32'h13C, 32'h11, 32'h400, 0, 1);

        // Back-pressure: hold for three cycles, then the next bundle follows.
        go(32'h300, mk(4'd2, 6'd17, 6'd2, 6'd1, 10'd0), 1'b0,
           32'h22, 32'h11, 32'h400, 32'h22, 32'h11, 32'h400, 0, -1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h304; in_inst = mk(4'd2, 6'd18, 6'd1, 6'd2, 10'd0); in_svpc = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", c), 32'(a_in_ready), 32'd0);
            chk($sformatf("bp_valid_%0d", c), 32'(a_out_valid), 32'd1);
            chk($sformatf("bp_pc_%0d", c), a_out_pc, 32'h300);
            chk($sformatf("bp_lhs_%0d", c), a_out_lhs, 32'h22);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a_in_ready), 32'd1);
        if (a_in_ready === 1'b1)
            sb.push_back('{32'h304, 32'h11, 32'h22, 32'h800, 32'h11, 32'h22, 32'h800, 6'd18, 4'd2});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_next_valid", 32'(a_out_valid), 32'd1);
        chk("bp_next_pc", a_out_pc, 32'h304);
        @(negedge clk);

        // Flush a stalled bundle; the write during the flush still lands.
        issue(32'h400, mk(4'd2, 6'd19, 6'd1, 6'd1, 10'd0), 1'b0, 1'b0, dummy, w, ov);
        out_ready = 1'b0; flush = 1'b1;
        in_valid = 1'b1; in_pc = 32'h404; in_inst = mk(4'd1, 6'd21, 6'd20, 6'd1, 10'd0); in_svpc = 1'b0;
        wb_we = 1'b1; wb_addr = 6'd20; wb_data = 32'h2020;
        #1;
        chk("flush_a_in_ready", 32'(a_in_ready), 32'd0);
        chk("flush_b_in_ready", 32'(b_in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; wb_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush_a_valid", 32'(a_out_valid), 32'd0);
        chk("flush_b_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        go(32'h404, mk(4'd1, 6'd21, 6'd20, 6'd1, 10'd0), 1'b0,
           32'h2020, 32'h11, 32'h400, 32'h2020, 32'h11, 32'h400, 0, -1);

        // Reset during a load-use stall with back-pressure.
        issue(32'h500, mk(4'd4, 6'd22, 6'd1, 6'd2, 10'd0), 1'b0, 1'b0, dummy, w, ov);
        out_ready = 1'b0; rst = 1'b1;
        in_valid = 1'b1; in_pc = 32'h504; in_inst = mk(4'd1, 6'd23, 6'd22, 6'd1, 10'd0); in_svpc = 1'b0;
        #1;
        chk("rst_stall_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_stall_valid", 32'(a_out_valid), 32'd0);
        chk("rst_stall_ready_after", 32'(a_in_ready), 32'd1);
        // Registers were cleared, so r1 now reads zero.
        go(32'h504, mk(4'd1, 6'd23, 6'd22, 6'd1, 10'd0), 1'b0,
           32'h0, 32'h0, 32'h400, 32'h0, 32'h0, 32'h400, 0, 0);

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0) break;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
